// File: rtl/axi_err_slv_burst.sv
// ============================================================================
// Module  : axi_err_slv_burst
// Brief   : AXI4 error slave; drains write bursts, returns RESP on B and R beats.
//           Optional capture of the first unmapped access: ERR_SLV_LOG_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_err_slv_burst #(
   parameter int          ID_W    = 4,
   parameter int          ADDR_W  = 32,
   parameter int          DATA_W  = 32,
   parameter int          MAX_TXN = 2,
   parameter logic [1:0]  RESP    = 2'b11,
   parameter logic [31:0] RDATA   = 32'hBADCAB1E
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [ID_W-1:0]   s_awid,
   input  logic [ADDR_W-1:0] s_awaddr,
   input  logic [7:0]        s_awlen,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic              s_wlast,
   input  logic              s_wvalid,
   output logic              s_wready,
   output logic [ID_W-1:0]   s_bid,
   output logic [1:0]        s_bresp,
   output logic              s_bvalid,
   input  logic              s_bready,
   input  logic [ID_W-1:0]   s_arid,
   input  logic [ADDR_W-1:0] s_araddr,
   input  logic [7:0]        s_arlen,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [ID_W-1:0]   s_rid,
   output logic [DATA_W-1:0] s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rlast,
   output logic              s_rvalid,
   input  logic              s_rready
`ifdef ERR_SLV_LOG_EN
   ,
   output logic              err_valid_o,
   output logic [ADDR_W-1:0] err_addr_o,
   output logic              err_is_wr_o,
   input  logic              err_clr_i
`endif
);

   localparam int             c_PW       = (MAX_TXN > 1) ? $clog2(MAX_TXN) : 1;
   localparam int             c_CW       = $clog2(MAX_TXN + 1);
   localparam int             c_ARW      = ID_W + 8;
   localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(MAX_TXN - 1);
   localparam logic [c_CW-1:0] c_FULL     = c_CW'(MAX_TXN);
   localparam logic [DATA_W-1:0] c_RDATA  = DATA_W'(RDATA);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   // Holds the address channels not-ready for the first cycle after reset.
   logic r_live;

   always_ff @(posedge aclk) begin
      if (areset) r_live <= 1'b0;
      else        r_live <= 1'b1;
   end

   // ---------------- write path ----------------
   logic [ID_W-1:0] r_aw_mem [MAX_TXN];
   logic [c_PW-1:0] r_aw_wr, r_aw_rd;
   logic [c_CW-1:0] r_aw_cnt;
   logic            r_bvalid;
   logic [ID_W-1:0] r_bid;
   logic            w_aw_push, w_aw_pop;

   assign s_awready = r_live & (r_aw_cnt != c_FULL);
   assign s_wready  = (r_aw_cnt != '0) & ~r_bvalid;
   assign w_aw_push = s_awvalid & s_awready;
   assign w_aw_pop  = s_wvalid & s_wready & s_wlast;

   always_ff @(posedge aclk) begin
      if (w_aw_push) r_aw_mem[r_aw_wr] <= s_awid;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_aw_wr  <= '0;
         r_aw_rd  <= '0;
         r_aw_cnt <= '0;
      end else begin
         if (w_aw_push) r_aw_wr <= (r_aw_wr == c_PTR_LAST) ? '0 : r_aw_wr + 1'b1;
         if (w_aw_pop)  r_aw_rd <= (r_aw_rd == c_PTR_LAST) ? '0 : r_aw_rd + 1'b1;
         r_aw_cnt <= r_aw_cnt + c_CW'(w_aw_push) - c_CW'(w_aw_pop);
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_bvalid <= 1'b0;
         r_bid    <= '0;
      end else if (w_aw_pop) begin
         r_bvalid <= 1'b1;
         r_bid    <= r_aw_mem[r_aw_rd];
      end else if (s_bready) begin
         r_bvalid <= 1'b0;
      end
   end

   assign s_bvalid = r_bvalid;
   assign s_bid    = r_bid;
   assign s_bresp  = RESP;

   // ---------------- read path ----------------
   logic [c_ARW-1:0] r_ar_mem [MAX_TXN];
   logic [c_PW-1:0]  r_ar_wr, r_ar_rd;
   logic [c_CW-1:0]  r_ar_cnt;
   logic [0:0]       r_rstate;
   logic [ID_W-1:0]  r_rid;
   logic [7:0]       r_rlen, r_rcnt;
   logic             w_ar_push, w_ar_pop, w_ar_empty, w_r_fire, w_r_last;
   logic [c_ARW-1:0] w_ar_head;

   assign s_arready  = r_live & (r_ar_cnt != c_FULL);
   assign w_ar_push  = s_arvalid & s_arready;
   assign w_ar_empty = (r_ar_cnt == '0);
   // An empty FIFO forwards the incoming request so an idle engine starts next cycle.
   assign w_ar_head  = w_ar_empty ? {s_arid, s_arlen} : r_ar_mem[r_ar_rd];
   assign w_r_fire   = s_rvalid & s_rready;
   assign w_r_last   = (r_rcnt == r_rlen);
   assign w_ar_pop   = ((r_rstate == S_IDLE) & (~w_ar_empty | w_ar_push)) |
                       (w_r_fire & w_r_last & ~w_ar_empty);

   always_ff @(posedge aclk) begin
      if (w_ar_push) r_ar_mem[r_ar_wr] <= {s_arid, s_arlen};
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_ar_wr  <= '0;
         r_ar_rd  <= '0;
         r_ar_cnt <= '0;
      end else begin
         if (w_ar_push) r_ar_wr <= (r_ar_wr == c_PTR_LAST) ? '0 : r_ar_wr + 1'b1;
         if (w_ar_pop)  r_ar_rd <= (r_ar_rd == c_PTR_LAST) ? '0 : r_ar_rd + 1'b1;
         r_ar_cnt <= r_ar_cnt + c_CW'(w_ar_push) - c_CW'(w_ar_pop);
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_rstate <= S_IDLE;
         r_rid    <= '0;
         r_rlen   <= '0;
         r_rcnt   <= '0;
      end else if (w_ar_pop) begin
         r_rstate <= S_BUSY;
         r_rid    <= w_ar_head[c_ARW-1:8];
         r_rlen   <= w_ar_head[7:0];
         r_rcnt   <= '0;
      end else if (w_r_fire) begin
         if (w_r_last) r_rstate <= S_IDLE;
         else          r_rcnt   <= r_rcnt + 8'd1;
      end
   end

   assign s_rvalid = (r_rstate == S_BUSY);
   assign s_rlast  = s_rvalid & w_r_last;
   assign s_rid    = r_rid;
   assign s_rdata  = c_RDATA;
   assign s_rresp  = RESP;

   // ---------------- optional error log ----------------
`ifdef ERR_SLV_LOG_EN
   logic              r_err_valid;
   logic [ADDR_W-1:0] r_err_addr;
   logic              r_err_is_wr;

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_err_valid <= 1'b0;
         r_err_addr  <= '0;
         r_err_is_wr <= 1'b0;
      end else if (err_clr_i) begin
         r_err_valid <= 1'b0;
      end else if (~r_err_valid & (w_ar_push | w_aw_push)) begin
         r_err_valid <= 1'b1;
         r_err_addr  <= w_ar_push ? s_araddr : s_awaddr;
         r_err_is_wr <= ~w_ar_push;
      end
   end

   assign err_valid_o = r_err_valid;
   assign err_addr_o  = r_err_addr;
   assign err_is_wr_o = r_err_is_wr;

   logic w_unused;
   assign w_unused = ^s_awlen;
`else
   logic w_unused;
   assign w_unused = ^{s_awlen, s_awaddr, s_araddr};
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_err_slv_burst.sv
// ============================================================================
// Module  : tb_axi_err_slv_burst
// Brief   : Directed self-checking bench for axi_err_slv_burst (default parameters).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_err_slv_burst;

   logic        aclk = 1'b0;
   logic        areset;
   logic [3:0]  s_awid, s_arid, s_bid, s_rid;
   logic [31:0] s_awaddr, s_araddr, s_rdata;
   logic [7:0]  s_awlen, s_arlen;
   logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
   logic [1:0]  s_bresp, s_rresp;
   logic        s_bvalid, s_bready, s_arvalid, s_arready;
   logic        s_rlast, s_rvalid, s_rready;
`ifdef ERR_SLV_LOG_EN
   logic        err_valid_o, err_is_wr_o, err_clr_i;
   logic [31:0] err_addr_o;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int beat;

   always #5 aclk = ~aclk;

   axi_err_slv_burst dut (
      .aclk(aclk), .areset(areset),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
`ifdef ERR_SLV_LOG_EN
      , .err_valid_o(err_valid_o), .err_addr_o(err_addr_o),
      .err_is_wr_o(err_is_wr_o), .err_clr_i(err_clr_i)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   initial begin
      areset = 1'b1;
      s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awvalid = 1'b0;
      s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
      s_arid = '0; s_araddr = '0; s_arlen = '0; s_arvalid = 1'b0; s_rready = 1'b0;
`ifdef ERR_SLV_LOG_EN
      err_clr_i = 1'b0;
`endif
      repeat (3) tick();
      check("rst_awready", s_awready, 0);
      check("rst_arready", s_arready, 0);
      check("rst_wready",  s_wready,  0);
      check("rst_bvalid",  s_bvalid,  0);
      check("rst_rvalid",  s_rvalid,  0);
      check("rst_bid",     s_bid,     0);
      check("rst_rid",     s_rid,     0);
      check("rst_rlast",   s_rlast,   0);

      areset = 1'b0;
      tick();
      check("awready_up", s_awready, 1);
      check("arready_up", s_arready, 1);
      tick();

      // Single-beat read, one cycle latency.
      s_arvalid = 1'b1; s_arid = 4'd3; s_arlen = 8'd0; s_rready = 1'b1;
      tick();
      s_arvalid = 1'b0;
      check("r1_valid", s_rvalid, 1);
      check("r1_rid",   s_rid,    3);
      check("r1_rlast", s_rlast,  1);
      check("r1_rdata", s_rdata,  32'hBADCAB1E);
      check("r1_rresp", s_rresp,  2'b11);
      tick();
      check("r1_done",  s_rvalid, 0);

      // Four-beat read with rready alternating 0/1.
      s_arvalid = 1'b1; s_arid = 4'd5; s_arlen = 8'd3; s_rready = 1'b0;
      tick();
      s_arvalid = 1'b0;
      beat = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         s_rready = (cyc % 2 == 1);
         check($sformatf("r4_valid_c%0d", cyc), s_rvalid, 1);
         check($sformatf("r4_rid_c%0d", cyc),   s_rid,    5);
         check($sformatf("r4_rlast_c%0d", cyc), s_rlast,  (beat == 3));
         tick();
         if (cyc % 2 == 1) beat++;
      end
      s_rready = 1'b0;
      check("r4_beats", beat, 4);
      check("r4_done",  s_rvalid, 0);

      // Eight-beat write burst, then a second AW while B is stalled.
      s_awvalid = 1'b1; s_awid = 4'd1; s_awlen = 8'd7; s_awaddr = 32'h100;
      tick();
      s_awvalid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_wvalid = 1'b1; s_wlast = (i == 7);
         check($sformatf("w_wready_%0d", i), s_wready, 1);
         tick();
      end
      s_wvalid = 1'b0; s_wlast = 1'b0;
      check("b1_valid", s_bvalid, 1);
      check("b1_bid",   s_bid,    1);
      check("b1_bresp", s_bresp,  2'b11);
      s_awvalid = 1'b1; s_awid = 4'd2;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b1; s_wlast = 1'b1;
      check("b_stall_wready", s_wready, 0);
      check("b_stall_bvalid", s_bvalid, 1);
      s_bready = 1'b1;
      tick();
      s_bready = 1'b0;
      check("b1_cleared", s_bvalid, 0);
      check("w2_wready",  s_wready, 1);
      tick();
      s_wvalid = 1'b0; s_wlast = 1'b0;
      check("b2_valid", s_bvalid, 1);
      check("b2_bid",   s_bid,    2);
      s_bready = 1'b1;
      tick();
      s_bready = 1'b0;
      check("b2_cleared", s_bvalid, 0);

      // Back-to-back reads with rready low fill the engine plus two FIFO slots.
      s_arlen = 8'd0; s_arvalid = 1'b1;
      s_arid = 4'hA; check("ar_a_ready", s_arready, 1); tick();
      s_arid = 4'hB; check("ar_b_ready", s_arready, 1); tick();
      s_arid = 4'hC; check("ar_c_ready", s_arready, 1); tick();
      s_arid = 4'hD; check("ar_full",    s_arready, 0);
      s_arvalid = 1'b0; s_rready = 1'b1;
      check("ord_a", s_rid, 4'hA); tick();
      check("ord_b", s_rid, 4'hB); tick();
      check("ord_c", s_rid, 4'hC);
      check("ord_c_valid", s_rvalid, 1); tick();
      check("ord_done", s_rvalid, 0);

      // Reset pulse in the middle of a four-beat read.
      s_arvalid = 1'b1; s_arid = 4'd6; s_arlen = 8'd3;
      tick();
      s_arvalid = 1'b0;
      tick();
      check("mid_beat2_valid", s_rvalid, 1);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      check("mid_rvalid", s_rvalid, 0);
      check("mid_rid",    s_rid,    0);
      check("mid_rlast",  s_rlast,  0);
      tick();
      check("mid_arready", s_arready, 1);
      check("mid_wready",  s_wready,  0);
      s_arvalid = 1'b1; s_arid = 4'd9; s_arlen = 8'd1;
      tick();
      s_arvalid = 1'b0;
      check("post_rid",    s_rid,   9);
      check("post_rlast0", s_rlast, 0);
      tick();
      check("post_rlast1", s_rlast, 1);
      tick();
      check("post_done", s_rvalid, 0);
      s_rready = 1'b0;

`ifdef ERR_SLV_LOG_EN
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      s_awvalid = 1'b1; s_awaddr = 32'h1FFF_0000; s_awid = 4'd0;
      tick();
      s_awvalid = 1'b0;
      s_arvalid = 1'b1; s_araddr = 32'h2000; s_arid = 4'd0; s_arlen = 8'd0;
      tick();
      s_arvalid = 1'b0;
      check("log_valid", err_valid_o, 1);
      check("log_addr",  err_addr_o,  32'h1FFF_0000);
      check("log_is_wr", err_is_wr_o, 1);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      check("log_clr", err_valid_o, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
